ahb_master_arbiter: RTL and testbench
=====================================

# ahb_master_arbiter

Two-master AHB-Lite arbiter that shares the single address/data path into `ahb_interconnect` between the RISC-V core (`core_wrapper`, master 0, default master) and a second bus master (boot loader / DMA engine, master 1). It grants ownership, muxes the address-phase and data-phase signals of the owning master onto the interconnect master port, and enforces burst integrity, locking and bounded hold time. It sits between the masters and `ahb_interconnect` inside `RISCV_SoC`.

## Interface
- `MAX_HOLD`, default 16: consecutive hready cycles an owner may hold the bus while the other master requests before it is forced off (range 1..255).
- `clk  in  1`: system clock; every register samples on the rising edge.
- `reset  in  1`: asynchronous, active-low reset. Asserting it (0) takes effect immediately without a clock edge.
- `m0_req, m1_req  in  1`: bus request from master 0 / master 1.
- `m0_lock, m1_lock  in  1`: locked-sequence request; the owner keeps the bus while both its lock and req are high.
- `m0_haddr, m1_haddr  in  32`: address-phase address.
- `m0_htrans, m1_htrans  in  2`: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `m0_hwrite, m1_hwrite  in  1`; `m0_hsize, m1_hsize  in  3`; `m0_hprot, m1_hprot  in  4`: address-phase controls.
- `m0_hwdata, m1_hwdata  in  32`: data-phase write data.
- `hready  in  1`: transfer-complete from the interconnect; also fanned out unchanged to both masters outside this block.
- `haddr  out  32`, `htrans  out  2`, `hwrite  out  1`, `hsize  out  3`, `hprot  out  4`: address phase to the interconnect, driven by the owner.
- `hwdata  out  32`: write data from the data-phase owner.
- `m0_grant, m1_grant  out  1`: one-hot ownership indication.
- `hmaster  out  1`: current address-phase owner.
- `hmaster_data  out  1`: data-phase owner, i.e. `hmaster` delayed by one accepted transfer.

## Operation
- State: `hmaster` (owner FSM, states OWN0/OWN1), `hmaster_data`, `hold_cnt` (8-bit, saturating at MAX_HOLD).
- Address mux (combinational): haddr/htrans/hwrite/hsize/hprot = owner's signals. The non-owner's signals are ignored.
- Data mux (combinational): hwdata = m{hmaster_data}_hwdata.
- `mX_grant = (hmaster == X)`.
- Arbitration is evaluated only on rising edges with hready=1 (cur = owner, oth = other). The first matching rule wins:
  1. cur_req=1 and cur_lock=1: keep.
  2. cur_htrans=SEQ or BUSY (burst in progress): keep.
  3. oth_req=1 and (cur_req=0 or hold_cnt ≥ MAX_HOLD): switch to oth.
  4. cur_req=0, oth_req=0, cur=1: switch to 0 (park on default master).
  5. Otherwise: keep.
- Every switch clears hold_cnt.
- On a keep: hold_cnt increments (saturating) if oth_req=1, and clears if oth_req=0.
- Every hready=1 edge: `hmaster_data <= hmaster` (its value before the update).
- hready=0 edges: all state holds, including hmaster_data and hold_cnt.

## Timing
- Reset values: hmaster=0, hmaster_data=0, hold_cnt=0, m0_grant=1, m1_grant=0. Address/data outputs then follow master 0's inputs combinationally.
- Grant latency: request sampled on a hready=1 edge with the switch condition met gives new grant/hmaster in that clock cycle (1 cycle). The new owner's first address phase is presented in the same cycle its grant is visible.
- Handover: the old owner's last address phase becomes its data phase on that same edge. hwdata stays on the old owner for that data phase (hmaster_data), then moves to the new owner.
- Wait states: hready held low for N cycles stretches everything by N. No grant change occurs during a wait state.
- Simultaneous requests out of reset: master 0 keeps the bus (already owner), and master 1 is served after MAX_HOLD or when master 0 drops req.
- Lock released mid-burst: the SEQ rule still holds the bus until a non-SEQ/BUSY beat.
- Reset asserted mid-transfer: immediate return to OWN0/hmaster_data=0. In-flight transfers are abandoned (the interconnect is reset together with this block).

## Test plan
- Reset: drive reset=0 with m1_req=1 → m0_grant=1, hmaster=0, hmaster_data=0, haddr=m0_haddr. Outputs are unchanged until reset=1.
- Handover: m0_req=0, m1_req=1, hready=1 → after 1 edge m1_grant=1, haddr=m1_haddr (0x2000_0000). On the next hready edge, hwdata switches to m1_hwdata.
- Fairness: both request, m0 issues NONSEQ singles, MAX_HOLD=4 → m0 keeps the bus for exactly 4 hready edges, then m1_grant=1 on the 5th. Repeat with m1 owner: the bus returns to m0 after 4.
- Burst/lock: m1 owns the bus, issues NONSEQ then 3×SEQ with m1_lock=1 while m0_req=1 and hold_cnt saturated → no switch until the edge after the first IDLE/NONSEQ with lock=0.
- Wait states: mid-handover hold hready=0 for 3 cycles → hmaster, hmaster_data and grants stay constant for 3 cycles, and the transition completes on the first hready=1 edge.
- Park: m1 owner, both req drop, htrans=IDLE → m0_grant=1 after 1 hready edge. Reset pulse during an m1 SEQ beat → m0_grant=1 immediately.

Source files
------------

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter: master 0 (core) is the default owner, master 1 is the
// secondary master. Muxes address/data phases and enforces lock, burst and hold limits.
module ahb_master_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_lock,
    input  logic        m1_lock,
    input  logic [31:0] m0_haddr,
    input  logic [31:0] m1_haddr,
    input  logic [1:0]  m0_htrans,
    input  logic [1:0]  m1_htrans,
    input  logic        m0_hwrite,
    input  logic        m1_hwrite,
    input  logic [2:0]  m0_hsize,
    input  logic [2:0]  m1_hsize,
    input  logic [3:0]  m0_hprot,
    input  logic [3:0]  m1_hprot,
    input  logic [31:0] m0_hwdata,
    input  logic [31:0] m1_hwdata,
    input  logic        hready,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    output logic        m0_grant,
    output logic        m1_grant,
    output logic        hmaster,
    output logic        hmaster_data
);
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;
    localparam logic [7:0] HOLD_LIM    = 8'(MAX_HOLD);

    typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} own_e;

    typedef struct packed {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [3:0]  hprot;
    } addr_phase_t;

    addr_phase_t [1:0]        ap;
    logic [1:0]               req;
    logic [1:0]               lock;
    logic [1:0][31:0]         wdata;

    own_e                     state;
    logic [7:0]               hold_cnt;

    logic                     cur;
    logic                     oth;
    logic                     cur_req;
    logic                     oth_req;
    logic                     locked;
    logic                     in_burst;
    logic                     switch_now;
    logic                     park_now;
    logic                     hand_over;
    logic                     next_owner;
    logic [7:0]               hold_inc;

    assign ap[0]    = '{haddr: m0_haddr, htrans: m0_htrans, hwrite: m0_hwrite,
                        hsize: m0_hsize, hprot: m0_hprot};
    assign ap[1]    = '{haddr: m1_haddr, htrans: m1_htrans, hwrite: m1_hwrite,
                        hsize: m1_hsize, hprot: m1_hprot};
    assign req      = {m1_req, m0_req};
    assign lock     = {m1_lock, m0_lock};
    assign wdata    = {m1_hwdata, m0_hwdata};

    assign hmaster  = state;
    assign haddr    = ap[state].haddr;
    assign htrans   = ap[state].htrans;
    assign hwrite   = ap[state].hwrite;
    assign hsize    = ap[state].hsize;
    assign hprot    = ap[state].hprot;
    assign hwdata   = wdata[hmaster_data];

    // Arbitration rules in priority order: lock, burst, contended switch, park.
    always_comb begin
        cur        = state;
        oth        = ~cur;
        cur_req    = req[cur];
        oth_req    = req[oth];
        locked     = cur_req & lock[cur];
        in_burst   = (ap[cur].htrans == HTRANS_SEQ) || (ap[cur].htrans == HTRANS_BUSY);
        switch_now = !locked && !in_burst && oth_req && (!cur_req || hold_cnt >= HOLD_LIM);
        park_now   = !locked && !in_burst && !cur_req && !oth_req && cur;
        hand_over  = switch_now || park_now;
        next_owner = switch_now ? oth : 1'b0;
        hold_inc   = (hold_cnt >= HOLD_LIM) ? HOLD_LIM : hold_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= OWN0;
            hmaster_data <= 1'b0;
            hold_cnt     <= 8'd0;
            m0_grant     <= 1'b1;
            m1_grant     <= 1'b0;
        end else if (hready) begin
            hmaster_data <= state;
            if (hand_over) begin
                state    <= own_e'(next_owner);
                m0_grant <= ~next_owner;
                m1_grant <= next_owner;
                hold_cnt <= 8'd0;
            end else if (oth_req) begin
                hold_cnt <= hold_inc;
            end else begin
                hold_cnt <= 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: directed scenarios plus randomized traffic against a
// rule-level ownership model.
module tb_ahb_master_arbiter;
    localparam int MAX_HOLD = 4;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [31:0] addr [2];
    logic [1:0]  trans [2];
    logic        wr [2];
    logic [2:0]  sz [2];
    logic [3:0]  prot [2];
    logic [31:0] wdat [2];
    logic        hready;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        m0_grant, m1_grant, hmaster, hmaster_data;

    int n_tests = 0;
    int n_fail  = 0;

    bit mdl_owner;
    bit mdl_data;
    int mdl_waited;

    ahb_master_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m1_req(req[1]),
        .m0_lock(lock[0]), .m1_lock(lock[1]),
        .m0_haddr(addr[0]), .m1_haddr(addr[1]),
        .m0_htrans(trans[0]), .m1_htrans(trans[1]),
        .m0_hwrite(wr[0]), .m1_hwrite(wr[1]),
        .m0_hsize(sz[0]), .m1_hsize(sz[1]),
        .m0_hprot(prot[0]), .m1_hprot(prot[1]),
        .m0_hwdata(wdat[0]), .m1_hwdata(wdat[1]),
        .hready(hready),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hprot(hprot),
        .hwdata(hwdata),
        .m0_grant(m0_grant), .m1_grant(m1_grant),
        .hmaster(hmaster), .hmaster_data(hmaster_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ownership model: advance on the edge using the inputs presented before it.
    task automatic tick();
        bit o, x, stay, nxt;
        if (hready) begin
            o    = mdl_owner;
            x    = ~o;
            stay = (req[o] && lock[o]) || trans[o] == 2'b11 || trans[o] == 2'b01;
            nxt  = o;
            if (!stay) begin
                if (req[x] && (!req[o] || mdl_waited >= MAX_HOLD)) nxt = x;
                else if (!req[o] && !req[x]) nxt = 1'b0;
            end
            mdl_data = o;
            if (nxt != o) mdl_waited = 0;
            else if (req[x]) mdl_waited = (mdl_waited < MAX_HOLD) ? mdl_waited + 1 : MAX_HOLD;
            else mdl_waited = 0;
            mdl_owner = nxt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req = 2'b00; lock = 2'b00; hready = 1'b1;
        trans[0] = 2'b00; trans[1] = 2'b00;
        mdl_owner = 1'b0; mdl_data = 1'b0; mdl_waited = 0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        req = 2'b10;
        tick();
        tick();
        n_tests++;
        if (hmaster !== 1'b1 || hmaster_data !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_setup: hmaster=%0b data=%0b want 1/1", hmaster, hmaster_data);
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({m0_grant, m1_grant, hmaster, hmaster_data} !== 4'b1000 || haddr !== addr[0]) begin
            n_fail++;
            $display("FAIL reset_async: g0=%0b g1=%0b hm=%0b hd=%0b haddr=%h want 1000 %h",
                     m0_grant, m1_grant, hmaster, hmaster_data, haddr, addr[0]);
        end
        repeat (3) begin
            @(posedge clk); #1;
            n_tests++;
            if ({m0_grant, m1_grant, hmaster, hmaster_data} !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset_held: g0=%0b g1=%0b hm=%0b hd=%0b want 1000",
                         m0_grant, m1_grant, hmaster, hmaster_data);
            end
        end
        reset = 1'b1;
        mdl_owner = 1'b0; mdl_data = 1'b0; mdl_waited = 0;
        req = 2'b00;
    endtask

    task automatic test_handover();
        do_reset();
        addr[0] = 32'h1000_0040; addr[1] = 32'h2000_0000;
        wdat[0] = 32'hAAAA_0000; wdat[1] = 32'h5555_1111;
        req = 2'b10;
        tick();
        n_tests++;
        if (m1_grant !== 1'b1 || m0_grant !== 1'b0 || haddr !== 32'h2000_0000) begin
            n_fail++;
            $display("FAIL handover_grant: g1=%0b g0=%0b haddr=%h want 1 0 20000000",
                     m1_grant, m0_grant, haddr);
        end
        n_tests++;
        if (hwdata !== 32'hAAAA_0000) begin
            n_fail++;
            $display("FAIL handover_old_data: hwdata=%h want aaaa0000", hwdata);
        end
        tick();
        n_tests++;
        if (hwdata !== 32'h5555_1111 || hmaster_data !== 1'b1) begin
            n_fail++;
            $display("FAIL handover_new_data: hwdata=%h hd=%0b want 55551111 1", hwdata, hmaster_data);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        req = 2'b11; lock = 2'b00;
        trans[0] = 2'b10; trans[1] = 2'b10;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_tests++;
            if (m0_grant !== 1'b1) begin
                n_fail++;
                $display("FAIL fair_m0_hold edge %0d: g0=%0b want 1", i, m0_grant);
            end
        end
        tick();
        n_tests++;
        if (m1_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL fair_m0_release: g1=%0b want 1", m1_grant);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_tests++;
            if (m1_grant !== 1'b1) begin
                n_fail++;
                $display("FAIL fair_m1_hold edge %0d: g1=%0b want 1", i, m1_grant);
            end
        end
        tick();
        n_tests++;
        if (m0_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL fair_m1_release: g0=%0b want 1", m0_grant);
        end
    endtask

    task automatic test_burst_lock();
        bit lk [3];
        lk[0] = 1'b1; lk[1] = 1'b0; lk[2] = 1'b0;
        do_reset();
        req = 2'b10;
        tick();
        req = 2'b11; lock = 2'b10; trans[1] = 2'b10; trans[0] = 2'b10;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tests++;
            if (m1_grant !== 1'b1) begin
                n_fail++;
                $display("FAIL lock_hold beat %0d: g1=%0b want 1", i, m1_grant);
            end
        end
        trans[1] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            lock[1] = lk[i];
            tick();
            n_tests++;
            if (m1_grant !== 1'b1) begin
                n_fail++;
                $display("FAIL burst_hold seq %0d: g1=%0b want 1", i, m1_grant);
            end
        end
        trans[1] = 2'b00; lock[1] = 1'b0;
        tick();
        n_tests++;
        if (m0_grant !== 1'b1 || hmaster !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_release: g0=%0b hm=%0b want 1 0", m0_grant, hmaster);
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        req = 2'b10;
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({hmaster, hmaster_data, m0_grant, m1_grant} !== 4'b0010) begin
                n_fail++;
                $display("FAIL wait_pre_switch %0d: hm=%0b hd=%0b g0=%0b g1=%0b want 0010",
                         i, hmaster, hmaster_data, m0_grant, m1_grant);
            end
        end
        hready = 1'b1;
        tick();
        n_tests++;
        if ({hmaster, hmaster_data, m0_grant, m1_grant} !== 4'b1001) begin
            n_fail++;
            $display("FAIL wait_switch: hm=%0b hd=%0b g0=%0b g1=%0b want 1001",
                     hmaster, hmaster_data, m0_grant, m1_grant);
        end
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({hmaster, hmaster_data} !== 2'b10) begin
                n_fail++;
                $display("FAIL wait_data_hold %0d: hm=%0b hd=%0b want 10", i, hmaster, hmaster_data);
            end
        end
        hready = 1'b1;
        tick();
        n_tests++;
        if (hmaster_data !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_data_move: hd=%0b want 1", hmaster_data);
        end
    endtask

    task automatic test_park();
        do_reset();
        req = 2'b10;
        tick();
        req = 2'b00; trans[1] = 2'b00;
        tick();
        n_tests++;
        if (m0_grant !== 1'b1 || hmaster !== 1'b0) begin
            n_fail++;
            $display("FAIL park: g0=%0b hm=%0b want 1 0", m0_grant, hmaster);
        end
        req = 2'b10; trans[1] = 2'b10;
        tick();
        trans[1] = 2'b11;
        tick();
        n_tests++;
        if (m1_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL park_seq_setup: g1=%0b want 1", m1_grant);
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({m0_grant, m1_grant, hmaster, hmaster_data} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_mid_seq: g0=%0b g1=%0b hm=%0b hd=%0b want 1000",
                     m0_grant, m1_grant, hmaster, hmaster_data);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        req = 2'b00; trans[1] = 2'b00;
        mdl_owner = 1'b0; mdl_data = 1'b0; mdl_waited = 0;
    endtask

    task automatic test_random();
        logic [31:0] exp_addr, exp_wdata;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req    = 2'($urandom);
            lock   = 2'($urandom_range(0, 3) == 0 ? $urandom : 0);
            hready = ($urandom_range(0, 3) != 0);
            for (int m = 0; m < 2; m++) begin
                addr[m]  = $urandom;
                trans[m] = 2'($urandom);
                wr[m]    = 1'($urandom);
                sz[m]    = 3'($urandom);
                prot[m]  = 4'($urandom);
                wdat[m]  = $urandom;
            end
            tick();
            exp_addr  = addr[mdl_owner];
            exp_wdata = wdat[mdl_data];
            n_tests++;
            if (hmaster !== mdl_owner || hmaster_data !== mdl_data ||
                m0_grant !== !mdl_owner || m1_grant !== mdl_owner ||
                haddr !== exp_addr || htrans !== trans[mdl_owner] ||
                hwrite !== wr[mdl_owner] || hsize !== sz[mdl_owner] ||
                hprot !== prot[mdl_owner] || hwdata !== exp_wdata) begin
                n_fail++;
                $display("FAIL random cyc %0d: hm=%0b hd=%0b g=%0b%0b haddr=%h hwdata=%h want hm=%0b hd=%0b haddr=%h hwdata=%h",
                         c, hmaster, hmaster_data, m1_grant, m0_grant, haddr, hwdata,
                         mdl_owner, mdl_data, exp_addr, exp_wdata);
            end
        end
    endtask

    initial begin
        reset = 1'b0; hready = 1'b1; req = 2'b00; lock = 2'b00;
        for (int m = 0; m < 2; m++) begin
            addr[m] = 32'h0; trans[m] = 2'b00; wr[m] = 1'b0;
            sz[m] = 3'd2; prot[m] = 4'h3; wdat[m] = 32'h0;
        end
        addr[0] = 32'h0000_1000; addr[1] = 32'h2000_0000;
        wdat[0] = 32'hC0DE_0000; wdat[1] = 32'hB007_0001;
        test_reset();
        test_handover();
        test_fairness();
        test_burst_lock();
        test_wait_states();
        test_park();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
